// File: rtl/cache_control.sv
// cache_control: control FSM for a 2-way set-associative cache.
//
// Purpose:
//   Accepts CPU read/write requests and reads both ways' hit/dirty status.
//   Completes hits in the winning way. A miss evicts the LRU way: dirty
//   lines are written back first, then the line is filled from physical
//   memory and the lookup is replayed. One LRU bit is kept per set.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   mem_read/mem_write  CPU request (write wins if both), held until mem_resp
//   mem_byte_enable     byte mask applied on a write hit
//   addr_index          set index, stable while the request is held
//   mem_resp            one-cycle completion pulse to the CPU
//   way_read            read strobe to both ways (data valid next cycle)
//   hit, dirty          per-way lookup status (bit w = way w)
//   load_tag/valid/dirty, load_data0/1, valid_in, dirty_in  way write controls
//   data_sel            way data_in mux: 0 = CPU data, 1 = pmem line
//   addr_sel            pmem address mux: 0 = request tag, 1 = victim tag
//   victim              way being evicted/filled (0 outside a miss)
//   pmem_read/write     fill / writeback request, held until pmem_resp
//   pmem_resp           memory completion pulse
//   hit_count, miss_count, wb_count  performance counters
//   state_dbg           current FSM state, for observation only
//
// Configuration:
//   CACHE_PERF_COUNTERS_EN  when defined, the three counters are live;
//                           otherwise they are tied to 0 and no flops exist.
//
// Handshake: a request is raised on mem_read/mem_write and held with a
// stable addr_index until the cycle mem_resp is high; that cycle completes
// it. pmem_read/pmem_write are raised by this block and held until the
// cycle pmem_resp is high; pmem_resp in any other state is ignored.

module cache_control #(
  parameter int  s_offset = 5,
  parameter int  s_index  = 3,
  localparam int s_mask   = 2**s_offset,
  localparam int num_sets = 2**s_index
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [s_mask-1:0]   mem_byte_enable,
  input  logic [s_index-1:0]  addr_index,
  output logic                mem_resp,
  output logic                way_read,
  input  logic [1:0]          hit,
  input  logic [1:0]          dirty,
  output logic [1:0]          load_tag,
  output logic [1:0]          load_valid,
  output logic [1:0]          load_dirty,
  output logic [s_mask-1:0]   load_data0,
  output logic [s_mask-1:0]   load_data1,
  output logic                valid_in,
  output logic                dirty_in,
  output logic                data_sel,
  output logic                addr_sel,
  output logic                victim,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    REREAD    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                victim_q;
  logic [num_sets-1:0] lru;
  logic                lru_we;
  logic                lru_val;
  logic                miss_take;
  logic                req;
  logic                hit_any;
  logic                hit_way;

  assign req     = mem_read | mem_write;
  assign hit_any = |hit;
  // Way 0 wins when both report a hit.
  assign hit_way = ~hit[0];
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      lru      <= '0;
    end else begin
      state_q <= state_d;
      // Victim is frozen at the miss so the whole burst targets one way.
      if (miss_take) victim_q <= lru[addr_index];
      if (lru_we)    lru[addr_index] <= lru_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    way_read   = 1'b0;
    load_tag   = 2'b00;
    load_valid = 2'b00;
    load_dirty = 2'b00;
    load_data0 = '0;
    load_data1 = '0;
    valid_in   = 1'b0;
    dirty_in   = 1'b0;
    data_sel   = 1'b0;
    addr_sel   = 1'b0;
    victim     = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    miss_take  = 1'b0;
    // Outputs are forced low for the whole time reset is held.
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            way_read = 1'b1;
            state_d  = LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req) begin
            state_d = IDLE;
          end else if (hit_any) begin
            mem_resp = 1'b1;
            lru_we   = 1'b1;
            lru_val  = ~hit_way;
            state_d  = IDLE;
            if (mem_write) begin
              load_dirty[hit_way] = 1'b1;
              dirty_in            = 1'b1;
              if (hit_way) load_data1 = mem_byte_enable;
              else         load_data0 = mem_byte_enable;
            end
          end else begin
            miss_take = 1'b1;
            // Dirty implies valid, so a dirty victim always needs writeback.
            state_d = dirty[lru[addr_index]] ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          victim     = victim_q;
          pmem_write = 1'b1;
          addr_sel   = 1'b1;
          if (pmem_resp) state_d = FILL;
        end
        FILL: begin
          victim    = victim_q;
          pmem_read = 1'b1;
          data_sel  = 1'b1;
          if (pmem_resp) begin
            if (victim_q) load_data1 = '1;
            else          load_data0 = '1;
            load_tag[victim_q]   = 1'b1;
            load_valid[victim_q] = 1'b1;
            load_dirty[victim_q] = 1'b1;
            valid_in             = 1'b1;
            dirty_in             = 1'b0;
            state_d              = REREAD;
          end
        end
        REREAD: begin
          victim   = victim_q;
          way_read = 1'b1;
          state_d  = LOOKUP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_COUNTERS_EN
  logic        from_reread_q;
  logic        lookup_req;
  logic [31:0] hit_q, miss_q, wb_q;

  assign lookup_req = (state_q == LOOKUP) && req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      from_reread_q <= 1'b0;
      hit_q         <= '0;
      miss_q        <= '0;
      wb_q          <= '0;
    end else begin
      // A replayed lookup after a fill is not a first-time hit.
      from_reread_q <= (state_q == REREAD);
      if (lookup_req && hit_any && !from_reread_q) hit_q  <= hit_q + 32'd1;
      if (lookup_req && !hit_any)                  miss_q <= miss_q + 32'd1;
      if ((state_q == WRITEBACK) && pmem_resp)     wb_q   <= wb_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule
